lc3_datapath: RTL and testbench
===============================

# lc3_datapath

LC-3 datapath that executes the control word issued each cycle by the control unit and supplies its status inputs. It holds PC, IR, MAR, MDR, the eight-entry register file, the condition codes and BEN. It also contains the ALU, the address adder, the mux tree and the single 16-bit processor bus. It sits between the control unit (upstream: control signals in; `ir`/`ben` out) and memory (downstream: `mar`/`mdr` out; `mem_rdata` in).

## Interface
- PC_RESET, 16'h3000, PC value loaded on reset
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- ld_ben, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc  in  1 each  register load enables
- gate_marmux, gate_mdr, gate_alu, gate_pc  in  1 each  bus drivers
- marmux, addr1mux  in  1 each  mux selects
- pcmux, addr2mux, drmux, sr1mux, aluk  in  2 each  mux / ALU selects
- mio_en  in  1  memory cycle active; selects `mem_rdata` as MDR source
- mem_rdata  in  16  data read from memory
- mar, mdr, ir  out  16 each  register contents
- ben  out  1  branch enable register
- cc  out  3  {N,Z,P}
- bus  out  16  current bus value (debug)
- bus_conflict  out  1  more than one gate asserted this cycle

## Operation
- Bus: combinational.
  - Priority is gate_pc > gate_mdr > gate_alu > gate_marmux.
  - The bus is 16'h0000 when no gate is asserted.
  - bus_conflict = (popcount of gates) > 1.
- Adder: ADDR1 + ADDR2, mod 2^16.
  - ADDR1: addr1mux 0 = PC, 1 = SR1out.
  - ADDR2: addr2mux 00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]), 11 = sext(IR[10:0]).
- MARMUX: 0 = zext(IR[7:0]), 1 = adder output.
- PCMUX: 00 = PC+1 (wraps FFFF→0000), 01 = bus, 10 = adder, 11 = PC (hold).
- SR1 address (sr1mux): 00 = IR[11:9], 01 = IR[8:6], 10/11 = R6.
- SR2: IR[5] ? sext(IR[4:0]) : R[IR[2:0]].
- DR address (drmux): 00 = IR[11:9], 01 = R7, 10/11 = R6.
- ALU (aluk): 00 = SR1+SR2 (mod 2^16), 01 = SR1&SR2, 10 = ~SR1, 11 = SR1 (pass).
- Register file: 8×16, two combinational read ports (SR1, SR2); write port R[DR] ← bus on ld_reg.
- MDR: on ld_mdr, mdr ← mio_en ? mem_rdata : bus.
- MAR ← bus on ld_mar; IR ← bus on ld_ir; PC ← PCMUX on ld_pc.
- CC on ld_cc, from bus:
  - N = bus[15].
  - Z = (bus == 0).
  - P = !N && !Z.
  - Exactly one bit is always set.
- BEN on ld_ben: (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using current IR and CC.
- Unused encodings have the defined behaviour stated above; no X is produced.

## Timing
- Reset values: PC = PC_RESET, IR = MAR = MDR = 16'h0000, R0–R7 = 16'h0000, cc = 3'b010, ben = 0. Reset overrides all loads in the same cycle.
- All registers load at posedge; the new value is visible the cycle after the load.
- Bus, adder, ALU, muxes and bus_conflict are purely combinational from current state and inputs; zero-cycle latency.
- Simultaneous loads use pre-edge values. Example, fetch: gate_pc + ld_mar + ld_pc, pcmux = 00 gives MAR ← old PC and PC ← old PC+1.
- Register-file read in the same cycle as a write to the same register returns the old value; no bypass.
- ld_reg with DR = SR1 (e.g. ADD R1,R1,#1) is well defined: the read uses the old value, the write lands at the edge.
- ld_ir and ld_ben in the same cycle: BEN uses the old IR.
- ld_cc and ld_ben in the same cycle: BEN uses the old CC.
- Reset asserted mid-instruction: all state returns to reset values at that edge; no partial update survives.

## Test plan
- Reset, then idle 3 cycles with all controls 0: PC = 3000, cc = 010, ben = 0, bus = 0000, bus_conflict = 0, R0–R7 all read 0000.
- Fetch, three sequential cycles:
  - gate_pc + ld_mar + ld_pc (pcmux = 00): MAR = 3000, PC = 3001.
  - mio_en + ld_mdr with mem_rdata = 1261: MDR = 1261.
  - gate_mdr + ld_ir: IR = 1261.
- ADD immediate: with R1 = 0005 and IR = 1261 (ADD R1,R1,#1), apply sr1mux = 01, drmux = 00, aluk = 00, gate_alu + ld_reg + ld_cc → R1 = 0006, cc = 001. Then IR = 947F (NOT R2,R1) with aluk = 10 → R2 = FFF9, cc = 100.
- Branch: IR = 0BFE (BRnp, off9 = −2), PC = 3001, cc = 100.
  - ld_ben → ben = 1.
  - pcmux = 10, addr1mux = 0, addr2mux = 10, ld_pc → PC = 2FFF.
  - Repeat with IR = 0402 (BRz) and cc = 001 → ben = 0.
- Wrap and JSR: PC = FFFF with ld_pc, pcmux = 00 → PC = 0000. Then gate_pc + ld_reg with drmux = 01 → R7 = 0000; the concurrent write reads the old R7.
- Bus conflict: assert gate_pc and gate_alu with PC = 3000 → bus = 3000, bus_conflict = 1. Assert reset during ld_pc → PC = 3000 next cycle.

Source files
------------

// File: rtl/lc3_datapath_if.sv
// LC-3 datapath port bundle.
// Control word and memory data in, status and registers out.
interface lc3_datapath_if;
  logic        ld_ben;
  logic        ld_mar;
  logic        ld_mdr;
  logic        ld_ir;
  logic        ld_pc;
  logic        ld_reg;
  logic        ld_cc;
  logic        gate_marmux;
  logic        gate_mdr;
  logic        gate_alu;
  logic        gate_pc;
  logic        marmux;
  logic        addr1mux;
  logic [1:0]  pcmux;
  logic [1:0]  addr2mux;
  logic [1:0]  drmux;
  logic [1:0]  sr1mux;
  logic [1:0]  aluk;
  logic        mio_en;
  logic [15:0] mem_rdata;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] ir;
  logic        ben;
  logic [2:0]  cc;
  logic [15:0] bus;
  logic        bus_conflict;

  modport master (
    output ld_ben, ld_mar, ld_mdr, ld_ir,
    output ld_pc, ld_reg, ld_cc,
    output gate_marmux, gate_mdr,
    output gate_alu, gate_pc,
    output marmux, addr1mux, pcmux,
    output addr2mux, drmux, sr1mux, aluk,
    output mio_en, mem_rdata,
    input  mar, mdr, ir, ben, cc,
    input  bus, bus_conflict
  );

  modport slave (
    input  ld_ben, ld_mar, ld_mdr, ld_ir,
    input  ld_pc, ld_reg, ld_cc,
    input  gate_marmux, gate_mdr,
    input  gate_alu, gate_pc,
    input  marmux, addr1mux, pcmux,
    input  addr2mux, drmux, sr1mux, aluk,
    input  mio_en, mem_rdata,
    output mar, mdr, ir, ben, cc,
    output bus, bus_conflict
  );
endinterface

// File: rtl/lc3_datapath.sv
// LC-3 datapath: PC/IR/MAR/MDR, register file, CC, BEN,
// ALU, address adder and the single processor bus.
module lc3_datapath #(
  parameter logic [15:0] PC_RESET = 16'h3000
) (
  input logic           clk,
  input logic           reset,
  lc3_datapath_if.slave dp
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, mar_q;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] rf_q [8];
  logic [2:0]  cc_q, cc_d;
  logic        ben_q, ben_d;
  logic [2:0]  sr1_a, dr_a;
  logic [15:0] sr1, sr2;
  logic [15:0] addr1, addr2, adder;
  logic [15:0] marmux_v, alu, bus;
  logic [2:0]  gcnt;

  // Register-file address selection.
  always_comb begin
    unique case (dp.sr1mux)
      2'b00:   sr1_a = ir_q[11:9];
      2'b01:   sr1_a = ir_q[8:6];
      default: sr1_a = 3'd6;
    endcase
    unique case (dp.drmux)
      2'b00:   dr_a = ir_q[11:9];
      2'b01:   dr_a = 3'd7;
      default: dr_a = 3'd6;
    endcase
  end

  // Operand reads, address adder and ALU.
  always_comb begin
    sr1 = rf_q[sr1_a];
    sr2 = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]}
                  : rf_q[ir_q[2:0]];
    addr1 = dp.addr1mux ? sr1 : pc_q;
    unique case (dp.addr2mux)
      2'b00:   addr2 = 16'h0000;
      2'b01:   addr2 = {{10{ir_q[5]}}, ir_q[5:0]};
      2'b10:   addr2 = {{7{ir_q[8]}}, ir_q[8:0]};
      default: addr2 = {{5{ir_q[10]}}, ir_q[10:0]};
    endcase
    adder = addr1 + addr2;
    marmux_v = dp.marmux ? adder
                         : {8'h00, ir_q[7:0]};
    unique case (dp.aluk)
      2'b00:   alu = sr1 + sr2;
      2'b01:   alu = sr1 & sr2;
      2'b10:   alu = ~sr1;
      default: alu = sr1;
    endcase
  end

  // Prioritised bus drive; conflict flags overlapping gates.
  always_comb begin
    if (dp.gate_pc)          bus = pc_q;
    else if (dp.gate_mdr)    bus = mdr_q;
    else if (dp.gate_alu)    bus = alu;
    else if (dp.gate_marmux) bus = marmux_v;
    else                     bus = 16'h0000;
    gcnt = {2'b00, dp.gate_pc}
         + {2'b00, dp.gate_mdr}
         + {2'b00, dp.gate_alu}
         + {2'b00, dp.gate_marmux};
  end

  // Next-state values for PC, MDR, CC and BEN.
  always_comb begin
    unique case (dp.pcmux)
      2'b00:   pc_d = pc_q + 16'd1;
      2'b01:   pc_d = bus;
      2'b10:   pc_d = adder;
      default: pc_d = pc_q;
    endcase
    mdr_d = dp.mio_en ? dp.mem_rdata : bus;
    if (bus[15])             cc_d = 3'b100;
    else if (bus == 16'h0)   cc_d = 3'b010;
    else                     cc_d = 3'b001;
    ben_d = |(ir_q[11:9] & cc_q);
  end

  // Architectural state; reset beats every load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      ir_q  <= 16'h0000;
      mar_q <= 16'h0000;
      mdr_q <= 16'h0000;
      cc_q  <= 3'b010;
      ben_q <= 1'b0;
      for (int i = 0; i < 8; i++)
        rf_q[i] <= 16'h0000;
    end else begin
      if (dp.ld_pc)  pc_q  <= pc_d;
      if (dp.ld_ir)  ir_q  <= bus;
      if (dp.ld_mar) mar_q <= bus;
      if (dp.ld_mdr) mdr_q <= mdr_d;
      if (dp.ld_cc)  cc_q  <= cc_d;
      if (dp.ld_ben) ben_q <= ben_d;
      if (dp.ld_reg) rf_q[dr_a] <= bus;
    end
  end

  assign dp.mar          = mar_q;
  assign dp.mdr          = mdr_q;
  assign dp.ir           = ir_q;
  assign dp.ben          = ben_q;
  assign dp.cc           = cc_q;
  assign dp.bus          = bus;
  assign dp.bus_conflict = (gcnt > 3'd1);

endmodule

// File: tb/tb_lc3_datapath.sv
// Directed bench for lc3_datapath.
// PC and registers are observed through the bus.
module tb_lc3_datapath;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  lc3_datapath_if dp_if ();

  lc3_datapath #(.PC_RESET(16'h3000)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  always #5 clk = ~clk;

  task automatic idle();
    dp_if.ld_ben = 0; dp_if.ld_mar = 0;
    dp_if.ld_mdr = 0; dp_if.ld_ir = 0;
    dp_if.ld_pc = 0; dp_if.ld_reg = 0;
    dp_if.ld_cc = 0;
    dp_if.gate_marmux = 0; dp_if.gate_mdr = 0;
    dp_if.gate_alu = 0; dp_if.gate_pc = 0;
    dp_if.marmux = 0; dp_if.addr1mux = 0;
    dp_if.pcmux = 2'b00; dp_if.addr2mux = 2'b00;
    dp_if.drmux = 2'b00; dp_if.sr1mux = 2'b00;
    dp_if.aluk = 2'b00;
    dp_if.mio_en = 0; dp_if.mem_rdata = 16'h0000;
  endtask

  // Apply edge, then clear controls away from it.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic load_mdr(input logic [15:0] v);
    dp_if.mio_en = 1; dp_if.ld_mdr = 1;
    dp_if.mem_rdata = v;
    tick();
  endtask

  task automatic load_ir(input logic [15:0] v);
    load_mdr(v);
    dp_if.gate_mdr = 1; dp_if.ld_ir = 1;
    tick();
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_mdr(v);
    dp_if.gate_mdr = 1; dp_if.ld_pc = 1;
    dp_if.pcmux = 2'b01;
    tick();
  endtask

  // Read SR1 through the ALU pass path.
  task automatic read_sr1(input string tag,
                          input logic [1:0] sel,
                          input logic [15:0] exp);
    dp_if.sr1mux = sel; dp_if.aluk = 2'b11;
    dp_if.gate_alu = 1;
    #1;
    chk(tag, dp_if.bus, exp);
    idle();
    #1;
  endtask

  task automatic read_pc(input string tag,
                         input logic [15:0] exp);
    dp_if.gate_pc = 1;
    #1;
    chk(tag, dp_if.bus, exp);
    idle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    idle();
    do_reset();
    repeat (3) tick();
    chk("rst_bus", dp_if.bus, 16'h0000);
    chk("rst_conf", {15'b0, dp_if.bus_conflict}, 16'h0);
    chk("rst_cc", {13'b0, dp_if.cc}, 16'h0002);
    chk("rst_ben", {15'b0, dp_if.ben}, 16'h0);
    chk("rst_mar", dp_if.mar, 16'h0000);
    chk("rst_mdr", dp_if.mdr, 16'h0000);
    chk("rst_ir", dp_if.ir, 16'h0000);
    read_pc("rst_pc", 16'h3000);
    for (int i = 0; i < 8; i++) begin
      load_ir({4'h0, 3'(i), 9'h000});
      read_sr1($sformatf("rst_r%0d", i), 2'b00, 16'h0);
    end

    do_reset();
    dp_if.gate_pc = 1; dp_if.ld_mar = 1;
    dp_if.ld_pc = 1; dp_if.pcmux = 2'b00;
    tick();
    chk("fetch_mar", dp_if.mar, 16'h3000);
    read_pc("fetch_pc", 16'h3001);
    dp_if.mio_en = 1; dp_if.ld_mdr = 1;
    dp_if.mem_rdata = 16'h1261;
    tick();
    chk("fetch_mdr", dp_if.mdr, 16'h1261);
    dp_if.gate_mdr = 1; dp_if.ld_ir = 1;
    tick();
    chk("fetch_ir", dp_if.ir, 16'h1261);

    load_mdr(16'h0005);
    dp_if.gate_mdr = 1; dp_if.ld_reg = 1;
    tick();
    read_sr1("r1_init", 2'b01, 16'h0005);
    dp_if.sr1mux = 2'b01; dp_if.aluk = 2'b00;
    dp_if.gate_alu = 1; dp_if.ld_reg = 1;
    dp_if.ld_cc = 1;
    #1;
    chk("add_bus_old", dp_if.bus, 16'h0006);
    tick();
    chk("add_cc", {13'b0, dp_if.cc}, 16'h0001);
    read_sr1("add_r1", 2'b01, 16'h0006);

    load_ir(16'h947F);
    dp_if.sr1mux = 2'b01; dp_if.aluk = 2'b10;
    dp_if.gate_alu = 1; dp_if.ld_reg = 1;
    dp_if.ld_cc = 1;
    tick();
    chk("not_cc", {13'b0, dp_if.cc}, 16'h0004);
    read_sr1("not_r2", 2'b00, 16'hFFF9);

    load_ir(16'h0BFE);
    dp_if.ld_ben = 1;
    tick();
    chk("brnp_ben", {15'b0, dp_if.ben}, 16'h1);
    dp_if.pcmux = 2'b10; dp_if.addr1mux = 0;
    dp_if.addr2mux = 2'b10; dp_if.ld_pc = 1;
    tick();
    read_pc("br_pc", 16'h2FFF);

    load_ir(16'h0402);
    load_mdr(16'h0001);
    dp_if.gate_mdr = 1; dp_if.ld_cc = 1;
    tick();
    chk("set_cc_p", {13'b0, dp_if.cc}, 16'h0001);
    dp_if.ld_ben = 1;
    tick();
    chk("brz_ben", {15'b0, dp_if.ben}, 16'h0);
    load_mdr(16'h0BFE);
    dp_if.gate_mdr = 1; dp_if.ld_ir = 1;
    dp_if.ld_ben = 1;
    tick();
    chk("ben_old_ir", {15'b0, dp_if.ben}, 16'h0);
    dp_if.ld_ben = 1;
    tick();
    chk("ben_new_ir", {15'b0, dp_if.ben}, 16'h1);

    load_ir(16'h01C0);
    dp_if.gate_marmux = 1; dp_if.marmux = 0;
    #1;
    chk("marmux_zext", dp_if.bus, 16'h00C0);
    idle();
    load_mdr(16'h1234);
    dp_if.gate_mdr = 1; dp_if.ld_reg = 1;
    dp_if.drmux = 2'b01;
    tick();
    read_sr1("r7_init", 2'b01, 16'h1234);

    set_pc(16'hFFFF);
    read_pc("pc_ffff", 16'hFFFF);
    dp_if.ld_pc = 1; dp_if.pcmux = 2'b00;
    tick();
    read_pc("pc_wrap", 16'h0000);
    dp_if.gate_pc = 1; dp_if.ld_reg = 1;
    dp_if.drmux = 2'b01;
    tick();
    read_sr1("jsr_r7", 2'b01, 16'h0000);

    set_pc(16'h3000);
    dp_if.gate_pc = 1; dp_if.gate_alu = 1;
    #1;
    chk("conf_bus", dp_if.bus, 16'h3000);
    chk("conf_flag", {15'b0, dp_if.bus_conflict}, 16'h1);
    idle();
    #1;

    set_pc(16'h4000);
    load_mdr(16'h1234);
    dp_if.gate_mdr = 1; dp_if.ld_pc = 1;
    dp_if.pcmux = 2'b01; dp_if.ld_cc = 1;
    reset = 1;
    tick();
    reset = 0;
    read_pc("midrst_pc", 16'h3000);
    chk("midrst_cc", {13'b0, dp_if.cc}, 16'h0002);
    chk("midrst_ir", dp_if.ir, 16'h0000);
    read_sr1("midrst_r7", 2'b10, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
